fxyz_sweep_ctrl: RTL
====================

// Module: fxyz_sweep_ctrl
// PURPOSE
//  Sequencer and self-checker for the combinational fxyz block (s1, s2 from x, y, z).
//  On start it drives all 8 {x,y,z} vectors in order 000..111, waits SETTLE cycles per vector,
//  samples s1/s2 and compares them against parameterised truth tables.
//  Reports pass/fail, a per-vector fail mask and an error count. Sits beside the fxyz instance
//  as its on-chip BIST controller.
// PARAMETERS
//  SETTLE  1      wait cycles between driving a vector and sampling it (0..15; 0 = no wait state)
//  EXP_S1  8'h70  expected s1, bit i = vector {x,y,z}==i (s1 = x & ~(y & z))
//  EXP_S2  8'h70  expected s2, bit i = vector {x,y,z}==i (s2 = x & ~(y & z))
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  start      in   1  level-sampled; accepted only in IDLE
//  abort      in   1  synchronous abort of a running sweep
//  s1         in   1  fxyz output s1
//  s2         in   1  fxyz output s2
//  x          out  1  fxyz input x (registered)
//  y          out  1  fxyz input y (registered)
//  z          out  1  fxyz input z (registered)
//  busy       out  1  sweep in progress (DRIVE/WAIT/SAMPLE)
//  done       out  1  one-cycle pulse at sweep completion
//  pass       out  1  last completed sweep had zero mismatches; held until next start/abort
//  err_count  out  4  number of mismatching vectors in current/last sweep (0..8)
//  fail_mask  out  8  bit i set if vector i mismatched on s1 or s2
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; x=y=z=0, busy=0, done=0, pass=0, err_count=0,
//    fail_mask=0. Effective immediately, including mid-sweep.
//  - {x,y,z} = 3-bit vector index idx. idx is 0 in IDLE and DONE.
//  - FSM states:
//    - IDLE: if start -> DRIVE; idx=0; err_count, fail_mask and pass cleared.
//    - DRIVE: 1 cycle; vector idx presented. Goes to WAIT (wait counter=SETTLE) if SETTLE>0,
//      else to SAMPLE.
//    - WAIT: counter decrements; -> SAMPLE when it reaches 1.
//    - SAMPLE: mismatch = (s1!=EXP_S1[idx]) | (s2!=EXP_S2[idx]). On mismatch:
//      fail_mask[idx]<=1, err_count<=err_count+1. Then idx==7 -> DONE, else idx+1 -> DRIVE.
//    - DONE: done=1 for this cycle; pass<=(final err_count==0); -> IDLE unconditionally.
//  - Per-vector cost: SETTLE+2 cycles. done goes high 8*(SETTLE+2) edges after the edge that
//    accepted start (24 for SETTLE=1).
//  - busy=1 in DRIVE, WAIT and SAMPLE only.
//  - start while busy or in DONE: ignored; no restart, no counter clear.
//  - abort in DRIVE/WAIT/SAMPLE: -> IDLE next edge; done not pulsed; pass=0; idx=0.
//    fail_mask and err_count keep their partial values. abort has priority over start and
//    over the SAMPLE update. abort in IDLE/DONE: no effect.
//  - err_count cannot overflow (max 8 fits in 4 bits). fail_mask only sets bits; cleared
//    solely on start accept or reset.
// CONFIGURATION
//  FXYZ_SWEEP_SIG_EN defined:
//    - adds output sig [7:0], a rotate-XOR signature. Cleared on start accept/reset.
//    - each SAMPLE updates it: sig <= {sig[6:0],sig[7]} ^ {6'b0,s1,s2}. Abort freezes it.
//  FXYZ_SWEEP_SIG_EN undefined: sig port and logic absent; all other behaviour identical.
// TESTING
//  1. Assert rst_n=0 mid-sweep (idx=5) -> same cycle: x,y,z=000, busy=0, done=0, pass=0,
//     err_count=0, fail_mask=00.
//  2. Golden fxyz, SETTLE=1, 1-cycle start pulse -> xyz steps 000..111 (3 cycles each);
//     done at edge 24; pass=1, err_count=0, fail_mask=8'h00.
//  3. s2 stuck-at-1, s1 golden -> fail_mask=8'h8F, err_count=5, pass=0, done still at edge 24.
//  4. start held high through a full sweep -> single sweep until done; next sweep begins
//     the edge after DONE->IDLE with err_count/fail_mask cleared.
//  5. abort asserted in SAMPLE of idx=3 with a fault on vector 1 -> IDLE next edge, no done,
//     busy=0, pass=0, fail_mask=8'h02, err_count=1.
//  6. FXYZ_SWEEP_SIG_EN, golden fxyz -> sig=8'h12 at done.
//     SETTLE=0 run -> done at edge 16, results identical to scenario 2.

Source files
------------

// File: rtl/fxyz_sweep_ctrl.sv
// fxyz_sweep_ctrl: on-chip BIST sequencer for the combinational fxyz block.
// Walks {x,y,z} through 000..111, lets each vector settle for SETTLE cycles,
// samples s1/s2 against the expected truth tables and accumulates a per-vector
// fail mask, an error count and a pass flag.
// Optional feature: define FXYZ_SWEEP_SIG_EN to add the sig_o rotate-XOR signature.
//
// state  | meaning
// IDLE   | waiting for start_i; idx held at 0
// DRIVE  | vector idx presented on x/y/z for one cycle
// WAIT   | settle countdown (skipped when SETTLE == 0)
// SAMPLE | compare s1/s2 with expected bits, then advance or finish
// DONE   | one-cycle done pulse, back to IDLE
module fxyz_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXP_S1 = 8'h70,
  parameter logic [7:0]  EXP_S2 = 8'h70
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       s1_i,
  input  logic       s2_i,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [7:0] fail_mask_o
`ifdef FXYZ_SWEEP_SIG_EN
  ,
  output logic [7:0] sig_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] err_q, err_d;
  logic [7:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic       busy;
  logic       mismatch;
`ifdef FXYZ_SWEEP_SIG_EN
  logic [7:0] sig_q, sig_d;
`endif

  assign busy     = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign mismatch = (s1_i != EXP_S1[idx_q]) || (s2_i != EXP_S2[idx_q]);

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      wait_q  <= 4'd0;
      err_q   <= 4'd0;
      mask_q  <= 8'd0;
      pass_q  <= 1'b0;
`ifdef FXYZ_SWEEP_SIG_EN
      sig_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
`ifdef FXYZ_SWEEP_SIG_EN
      sig_q   <= sig_d;
`endif
    end
  end

  // Next-state and result update; abort overrides whatever the busy states computed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
`ifdef FXYZ_SWEEP_SIG_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DRIVE;
          idx_d   = 3'd0;
          err_d   = 4'd0;
          mask_d  = 8'd0;
          pass_d  = 1'b0;
`ifdef FXYZ_SWEEP_SIG_EN
          sig_d   = 8'd0;
`endif
        end
      end
      ST_DRIVE: begin
        if (SETTLE_L != 4'd0) begin
          state_d = ST_WAIT;
          wait_d  = SETTLE_L;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_q + 4'd1;
        end
`ifdef FXYZ_SWEEP_SIG_EN
        sig_d = {sig_q[6:0], sig_q[7]} ^ {6'b0, s1_i, s2_i};
`endif
        if (idx_q == 3'd7) begin
          // pass is settled on entry to DONE so it is valid alongside the done pulse
          state_d = ST_DONE;
          idx_d   = 3'd0;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase

    if (abort_i && busy) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
      pass_d  = 1'b0;
      err_d   = err_q;
      mask_d  = mask_q;
`ifdef FXYZ_SWEEP_SIG_EN
      sig_d   = sig_q;
`endif
    end
  end

  assign x_o         = idx_q[2];
  assign y_o         = idx_q[1];
  assign z_o         = idx_q[0];
  assign busy_o      = busy;
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_mask_o = mask_q;
`ifdef FXYZ_SWEEP_SIG_EN
  assign sig_o       = sig_q;
`endif

endmodule
